// File: rtl/mem_req_demux_pkg.sv
// Shared definitions for the data-memory request path: widths, peripheral
// window decode defaults and the demux state encoding.
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 32;

  localparam logic [31:0] MEM_PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] MEM_PERIPH_MASK = 32'hF000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_req_demux.sv
// 1-to-2 data-memory request demux: routes one outstanding core request to
// data RAM (port 0) or the peripheral window (port 1) by address decode and
// steers the matching response back upstream.
module mem_req_demux
  import mem_pkg::*;
#(
  parameter int unsigned          DATA_W      = MEM_DATA_W,
  parameter int unsigned          ADDR_W      = MEM_ADDR_W,
  parameter logic [ADDR_W-1:0]    PERIPH_BASE = ADDR_W'(MEM_PERIPH_BASE),
  parameter logic [ADDR_W-1:0]    PERIPH_MASK = ADDR_W'(MEM_PERIPH_MASK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              m0_req_valid,
  input  logic              m0_req_ready,
  output logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_wdata,
  output logic              m0_we,
  input  logic              m0_resp_valid,
  input  logic [DATA_W-1:0] m0_rdata,
  output logic              m1_req_valid,
  input  logic              m1_req_ready,
  output logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_wdata,
  output logic              m1_we,
  input  logic              m1_resp_valid,
  input  logic [DATA_W-1:0] m1_rdata,
  output logic              stray_err
);

  state_t            state_q;
  state_t            state_d;
  logic              init_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              stray_q;

  logic              accept;
  logic              issuing;
  logic              sel_ready;
  logic              sel_resp;
  logic              other_resp;
  logic [DATA_W-1:0] sel_rdata;
  logic              stray_hit;

  // init_q keeps req_ready low until the first clock edge after reset.
  assign accept     = (state_q == ST_IDLE) && init_q && req_valid;
  assign issuing    = (state_q == ST_ISSUE);
  assign sel_ready  = sel_q ? m1_req_ready  : m0_req_ready;
  assign sel_resp   = sel_q ? m1_resp_valid : m0_resp_valid;
  assign other_resp = sel_q ? m0_resp_valid : m1_resp_valid;
  assign sel_rdata  = sel_q ? m1_rdata      : m0_rdata;
  assign stray_hit  = (state_q == ST_WAIT) ? other_resp
                                           : (m0_resp_valid || m1_resp_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: one request in flight, fixed IDLE->ISSUE->WAIT->RESP walk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_ISSUE;
      ST_ISSUE: if (sel_ready) state_d = ST_WAIT;
      ST_WAIT:  if (sel_resp)  state_d = ST_RESP;
      ST_RESP:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Request capture, response capture and sticky stray-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      stray_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        sel_q   <= ((req_addr & PERIPH_MASK) == PERIPH_BASE);
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state_q == ST_WAIT) && sel_resp)
        rdata_q <= we_q ? '0 : sel_rdata;
      if (stray_hit)
        stray_q <= 1'b1;
    end
  end

  // Output decode from registered state; the unselected port is held at zero.
  always_comb begin
    req_ready    = init_q && (state_q == ST_IDLE);
    resp_valid   = (state_q == ST_RESP);
    resp_rdata   = rdata_q;
    stray_err    = stray_q;
    m0_req_valid = issuing && !sel_q;
    m1_req_valid = issuing &&  sel_q;
    m0_addr      = m0_req_valid ? addr_q  : '0;
    m0_wdata     = m0_req_valid ? wdata_q : '0;
    m0_we        = m0_req_valid && we_q;
    m1_addr      = m1_req_valid ? addr_q  : '0;
    m1_wdata     = m1_req_valid ? wdata_q : '0;
    m1_we        = m1_req_valid && we_q;
  end

endmodule
